locked_core_key_loader: RTL and testbench
=========================================

// Module: locked_core_key_loader
// PURPOSE
//   Parametrised key-management front end for logic-locked HLS cores. It replaces a
//   hard-wired working_key constant with a key streamed in at run time in CHUNK_W-bit words.
//   It sits between the host ap_* handshake and the locked core, and forwards ap_start only
//   once a complete, well-framed key is loaded. The key is held stable while the core runs.
// PARAMETERS
//   KEY_BITS  6143  width of working_key driven to the locked core
//   CHUNK_W   32    width of one key chunk; NCHUNK = ceil(KEY_BITS/CHUNK_W)
// PORTS
//   ap_clk       in   1         clock
//   ap_rst       in   1         synchronous reset, active-high
//   key_valid    in   1         key chunk valid
//   key_ready    out  1         loader accepts a chunk (transfer = key_valid & key_ready)
//   key_data     in   CHUNK_W   key chunk, LSB chunk first
//   key_last     in   1         marks the final chunk of the key
//   key_clear    in   1         one-cycle request to discard the key
//   key_loaded   out  1         complete key held (ARMED or RUNNING)
//   key_err      out  1         framing error latched
//   working_key  out  KEY_BITS  key to the locked core
//   ap_start     in   1         host start
//   ap_done/ap_idle/ap_ready  out 1 each  host-side status
//   core_start   out  1         start to the locked core
//   core_done/core_idle/core_ready  in 1 each  locked-core status
// BEHAVIOUR
//   States: EMPTY, LOADING, ARMED, RUNNING, ERROR. Reset gives EMPTY, chunk count 0,
//     working_key 0, clear_pend 0.
//   Reset outputs: key_ready=1, key_loaded=0, key_err=0, core_start=0, ap_done=0,
//     ap_ready=0, ap_idle=1.
//   Chunk k (k = 0..NCHUNK-1) writes working_key[k*CHUNK_W +: CHUNK_W]. Bits of the last
//     chunk above KEY_BITS are discarded.
//   The write is registered: the key bits update on the cycle after the transfer.
//   EMPTY to LOADING on the first transfer. In EMPTY and LOADING, key_ready = 1.
//   Chunk NCHUNK-1 with key_last=1 moves the FSM to ARMED.
//   Framing error goes to ERROR. Either case is an error:
//     key_last=1 on any chunk before chunk NCHUNK-1, or
//     chunk NCHUNK-1 arriving with key_last=0.
//     ERROR sets key_err=1, zeroes working_key and the chunk count, and drives key_ready=0.
//   NCHUNK == 1: the first chunk must carry key_last=1. EMPTY then goes straight to ARMED.
//   In ARMED, RUNNING and ERROR, key_ready=0. Re-keying requires key_clear.
//   core_start = ap_start & (state==ARMED | state==RUNNING). It is combinational and obeys
//     the HLS rule that ap_start is held until ap_ready.
//   ARMED to RUNNING when core_start=1. RUNNING to ARMED on core_done, or to EMPTY on
//     core_done if clear_pend=1.
//   Status in ARMED and RUNNING: ap_done=core_done, ap_ready=core_ready, ap_idle=core_idle.
//   Status in other states: ap_done=0, ap_ready=0, ap_idle=1. ap_start is ignored and
//     core_start stays 0.
//   key_clear in EMPTY, LOADING, ARMED or ERROR: next cycle the FSM is EMPTY, working_key=0,
//     count=0 and key_err=0.
//   key_clear in RUNNING sets clear_pend. The key stays intact until core_done, then the
//     FSM goes to EMPTY with the key zeroed.
//   key_clear and a transfer in the same cycle: clear wins and the chunk is dropped.
//   ap_rst mid-load or mid-run: everything returns to reset values the next cycle.
//     The locked core is reset by the same ap_rst.
//   Latency: the key is usable (key_loaded=1) one cycle after the final chunk transfer.
// TESTING
//   Use KEY_BITS=70, CHUNK_W=32, NCHUNK=3 unless stated.
//   1. Chunks 0x11111111, 0x22222222, 0xFFFFFFC5 (last) -> working_key=70'h05_22222222_11111111,
//      key_loaded=1 next cycle.
//   2. key_last on chunk 1 -> key_err=1, working_key=0, key_ready=0.
//      Then key_clear -> EMPTY, key_err=0, key_ready=1.
//   3. ap_start=1 before the key is loaded -> core_start=0, ap_idle=1.
//      After scenario 1 -> core_start=1, ap_ready follows core_ready.
//   4. key_clear during RUNNING -> key unchanged until core_done pulses.
//      Next cycle working_key=0, key_loaded=0.
//   5. key_clear with key_valid on chunk 1 -> chunk dropped, count=0, working_key=0.
//   6. ap_rst after 2 chunks -> all outputs at reset values.
//      A full reload then succeeds as in scenario 1.

Source files
------------

// File: rtl/locked_core_key_loader_if.sv
// Purpose: bundles the key stream, host ap_* handshake and locked-core handshake of the key loader.
// Ports  : master = host/bench side (drives key chunks, ap_start, core status);
//          slave  = loader side (drives key_ready, status, working_key, core_start).
interface locked_core_key_loader_if #(
  parameter int KEY_BITS = 6143,
  parameter int CHUNK_W  = 32
);

  // key stream
  logic                key_valid;
  logic                key_ready;
  logic [CHUNK_W-1:0]  key_data;
  logic                key_last;
  logic                key_clear;
  logic                key_loaded;
  logic                key_err;
  logic [KEY_BITS-1:0] working_key;

  // host-side handshake
  logic                ap_start;
  logic                ap_done;
  logic                ap_idle;
  logic                ap_ready;

  // locked-core handshake
  logic                core_start;
  logic                core_done;
  logic                core_idle;
  logic                core_ready;

  modport master (
    output key_valid, key_data, key_last, key_clear,
    output ap_start,
    output core_done, core_idle, core_ready,
    input  key_ready, key_loaded, key_err, working_key,
    input  ap_done, ap_idle, ap_ready,
    input  core_start
  );

  modport slave (
    input  key_valid, key_data, key_last, key_clear,
    input  ap_start,
    input  core_done, core_idle, core_ready,
    output key_ready, key_loaded, key_err, working_key,
    output ap_done, ap_idle, ap_ready,
    output core_start
  );

endinterface

// File: rtl/locked_core_key_loader.sv
// Purpose : streams a KEY_BITS working key in CHUNK_W-bit words (LSB chunk first) and gates
//           ap_start to the locked core until a complete, well-framed key is held.
// Latency : each chunk lands in working_key one cycle after its transfer; key_loaded rises one
//           cycle after the final chunk. core_start / status pass-through are combinational.
// Backpressure: key_ready=1 only in EMPTY/LOADING; once armed, running or in error, no further
//           chunks are accepted until key_clear.
// Ports   : ap_clk, ap_rst (sync, active-high); bus (slave modport) carries key_valid/ready/data/
//           last/clear, key_loaded, key_err, working_key, ap_start/done/idle/ready and
//           core_start/done/idle/ready.
module locked_core_key_loader #(
  parameter int KEY_BITS = 6143,
  parameter int CHUNK_W  = 32
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst,
  locked_core_key_loader_if.slave        bus
);

  localparam int NCHUNK  = (KEY_BITS + CHUNK_W - 1) / CHUNK_W;
  localparam int CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  // The final chunk may be partial: only its low LAST_W bits are kept.
  localparam int LAST_LO = (NCHUNK - 1) * CHUNK_W;
  localparam int LAST_W  = KEY_BITS - LAST_LO;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NCHUNK - 1);

  typedef enum logic [2:0] {
    S_EMPTY,
    S_LOADING,
    S_ARMED,
    S_RUNNING,
    S_ERROR
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [KEY_BITS-1:0] key_q;
  logic                clear_pend_q;

  logic                is_last;
  logic                xfer;
  logic                core_start_c;
  logic                do_write;
  logic                do_zero;
  logic                set_pend;

  assign is_last = (cnt_q == LAST_IDX);

  // Next-state and outputs
  always_comb begin
    state_d        = state_q;
    do_write       = 1'b0;
    do_zero        = 1'b0;
    set_pend       = 1'b0;
    bus.key_ready  = 1'b0;
    bus.key_loaded = 1'b0;
    bus.key_err    = 1'b0;
    bus.ap_done    = 1'b0;
    bus.ap_ready   = 1'b0;
    bus.ap_idle    = 1'b1;
    core_start_c   = 1'b0;
    xfer           = 1'b0;

    case (state_q)
      S_EMPTY, S_LOADING: begin
        bus.key_ready = 1'b1;
        xfer          = bus.key_valid;
        if (bus.key_clear) begin
          // clear wins over a simultaneous transfer; the chunk is dropped
          do_zero = 1'b1;
          state_d = S_EMPTY;
        end else if (xfer) begin
          // key_last must coincide exactly with the final chunk index
          if (bus.key_last != is_last) begin
            do_zero = 1'b1;
            state_d = S_ERROR;
          end else begin
            do_write = 1'b1;
            state_d  = is_last ? S_ARMED : S_LOADING;
          end
        end
      end

      S_ARMED: begin
        bus.key_loaded = 1'b1;
        core_start_c   = bus.ap_start;
        bus.ap_done    = bus.core_done;
        bus.ap_ready   = bus.core_ready;
        bus.ap_idle    = bus.core_idle;
        if (bus.key_clear) begin
          do_zero = 1'b1;
          state_d = S_EMPTY;
        end else if (core_start_c) begin
          state_d = S_RUNNING;
        end
      end

      S_RUNNING: begin
        bus.key_loaded = 1'b1;
        core_start_c   = bus.ap_start;
        bus.ap_done    = bus.core_done;
        bus.ap_ready   = bus.core_ready;
        bus.ap_idle    = bus.core_idle;
        // The key must stay intact while the core computes, so a clear is deferred
        // until core_done; a clear arriving on the done cycle itself is honoured too.
        if (bus.core_done) begin
          if (clear_pend_q || bus.key_clear) begin
            do_zero = 1'b1;
            state_d = S_EMPTY;
          end else begin
            state_d = S_ARMED;
          end
        end else if (bus.key_clear) begin
          set_pend = 1'b1;
        end
      end

      S_ERROR: begin
        bus.key_err = 1'b1;
        if (bus.key_clear) begin
          do_zero = 1'b1;
          state_d = S_EMPTY;
        end
      end

      default: begin
        do_zero = 1'b1;
        state_d = S_EMPTY;
      end
    endcase

    bus.core_start = core_start_c;
  end

  // State, chunk counter, key register and deferred-clear flag
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= S_EMPTY;
      cnt_q        <= '0;
      key_q        <= '0;
      clear_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (do_zero) begin
        cnt_q        <= '0;
        key_q        <= '0;
        clear_pend_q <= 1'b0;
      end else begin
        if (set_pend) begin
          clear_pend_q <= 1'b1;
        end
        if (do_write) begin
          cnt_q <= is_last ? '0 : cnt_q + CNT_W'(1);
          for (int k = 0; k < NCHUNK - 1; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              key_q[k*CHUNK_W +: CHUNK_W] <= bus.key_data;
            end
          end
          if (is_last) begin
            key_q[KEY_BITS-1:LAST_LO] <= bus.key_data[LAST_W-1:0];
          end
        end
      end
    end
  end

  assign bus.working_key = key_q;

endmodule

// File: tb/tb_locked_core_key_loader.sv
module tb_locked_core_key_loader;

  localparam int KEY_BITS = 70;
  localparam int CHUNK_W  = 32;

  logic ap_clk = 1'b0;
  logic ap_rst;

  always #5 ap_clk = ~ap_clk;

  locked_core_key_loader_if #(.KEY_BITS(KEY_BITS), .CHUNK_W(CHUNK_W)) bus ();

  locked_core_key_loader #(.KEY_BITS(KEY_BITS), .CHUNK_W(CHUNK_W)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [KEY_BITS-1:0] exp_q[$];
  logic [KEY_BITS-1:0] key_a;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next active edge
  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic send(input logic [CHUNK_W-1:0] d, input logic last);
    bus.key_valid = 1'b1;
    bus.key_data  = d;
    bus.key_last  = last;
    tick();
    bus.key_valid = 1'b0;
    bus.key_last  = 1'b0;
    bus.key_data  = '0;
  endtask

  // push the expected key built from the chunks, then stream them in
  task automatic load_key(input logic [CHUNK_W-1:0] c0, input logic [CHUNK_W-1:0] c1,
                          input logic [CHUNK_W-1:0] c2);
    logic [KEY_BITS-1:0] e;
    e = {c2[KEY_BITS-2*CHUNK_W-1:0], c1, c0};
    exp_q.push_back(e);
    send(c0, 1'b0);
    send(c1, 1'b0);
    send(c2, 1'b1);
  endtask

  // wait (bounded) for key_loaded, then pop the scoreboard and compare
  task automatic check_key(input string tag);
    logic [KEY_BITS-1:0] e;
    int cyc;
    cyc = 0;
    while (bus.key_loaded !== 1'b1 && cyc < 8) begin
      tick();
      cyc++;
    end
    chk({tag, "_loaded"}, {127'b0, bus.key_loaded}, 128'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 128'd0, 128'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_key"}, {58'b0, bus.working_key}, {58'b0, e});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_key_ready"},  {127'b0, bus.key_ready},  128'd1);
    chk({tag, "_key_loaded"}, {127'b0, bus.key_loaded}, 128'd0);
    chk({tag, "_key_err"},    {127'b0, bus.key_err},    128'd0);
    chk({tag, "_core_start"}, {127'b0, bus.core_start}, 128'd0);
    chk({tag, "_ap_done"},    {127'b0, bus.ap_done},    128'd0);
    chk({tag, "_ap_ready"},   {127'b0, bus.ap_ready},   128'd0);
    chk({tag, "_ap_idle"},    {127'b0, bus.ap_idle},    128'd1);
    chk({tag, "_wkey"},       {58'b0, bus.working_key}, 128'd0);
  endtask

  initial begin
    bus.key_valid  = 1'b0;
    bus.key_data   = '0;
    bus.key_last   = 1'b0;
    bus.key_clear  = 1'b0;
    bus.ap_start   = 1'b0;
    bus.core_done  = 1'b0;
    bus.core_idle  = 1'b1;
    bus.core_ready = 1'b0;
    ap_rst         = 1'b1;
    tick();
    tick();
    ap_rst = 1'b0;
    #1;
    check_reset_outputs("rst");

    // start requested before any key: must be blocked
    bus.ap_start   = 1'b1;
    bus.core_ready = 1'b1;
    bus.core_idle  = 1'b0;
    #1;
    chk("nokey_core_start", {127'b0, bus.core_start}, 128'd0);
    chk("nokey_ap_idle",    {127'b0, bus.ap_idle},    128'd1);
    chk("nokey_ap_ready",   {127'b0, bus.ap_ready},   128'd0);
    bus.ap_start   = 1'b0;
    bus.core_ready = 1'b0;
    bus.core_idle  = 1'b1;

    // basic load, registered per-chunk write and key_loaded latency
    exp_q.push_back(70'h05_22222222_11111111);
    send(32'h11111111, 1'b0);
    chk("ld_chunk0", {58'b0, bus.working_key}, 128'h11111111);
    chk("ld_ready",  {127'b0, bus.key_ready}, 128'd1);
    send(32'h22222222, 1'b0);
    bus.key_valid = 1'b1;
    bus.key_data  = 32'hFFFFFFC5;
    bus.key_last  = 1'b1;
    #1;
    chk("ld_not_yet_loaded", {127'b0, bus.key_loaded}, 128'd0);
    tick();
    bus.key_valid = 1'b0;
    bus.key_last  = 1'b0;
    chk("ld_loaded_next", {127'b0, bus.key_loaded}, 128'd1);
    chk("ld_ready_low",   {127'b0, bus.key_ready},  128'd0);
    check_key("ld1");

    // start passes through once armed; ap_ready/ap_idle follow the core
    bus.ap_start = 1'b1;
    #1;
    chk("arm_core_start", {127'b0, bus.core_start}, 128'd1);
    chk("arm_ap_ready0",  {127'b0, bus.ap_ready},   128'd0);
    bus.core_ready = 1'b1;
    #1;
    chk("arm_ap_ready1",  {127'b0, bus.ap_ready},   128'd1);
    tick();
    bus.ap_start   = 1'b0;
    bus.core_ready = 1'b0;
    bus.core_idle  = 1'b0;
    #1;
    chk("run_core_start0", {127'b0, bus.core_start}, 128'd0);
    chk("run_ap_idle",     {127'b0, bus.ap_idle},    128'd0);
    bus.core_done = 1'b1;
    #1;
    chk("run_ap_done", {127'b0, bus.ap_done}, 128'd1);
    tick();
    bus.core_done = 1'b0;
    chk("done_rearmed", {127'b0, bus.key_loaded}, 128'd1);
    chk("done_key_kept", {58'b0, bus.working_key}, {58'b0, 70'h05_22222222_11111111});

    // clear during a run is deferred until core_done
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start  = 1'b0;
    bus.key_clear = 1'b1;
    tick();
    bus.key_clear = 1'b0;
    chk("pend_key_kept",  {58'b0, bus.working_key}, {58'b0, 70'h05_22222222_11111111});
    tick();
    chk("pend_key_kept2", {58'b0, bus.working_key}, {58'b0, 70'h05_22222222_11111111});
    chk("pend_loaded",    {127'b0, bus.key_loaded}, 128'd1);
    bus.core_done = 1'b1;
    tick();
    bus.core_done = 1'b0;
    chk("pend_key_zero", {58'b0, bus.working_key}, 128'd0);
    chk("pend_unloaded", {127'b0, bus.key_loaded}, 128'd0);
    chk("pend_ready",    {127'b0, bus.key_ready},  128'd1);
    chk("pend_ap_idle",  {127'b0, bus.ap_idle},    128'd1);
    bus.core_idle = 1'b1;

    // key_last too early
    send(32'hAAAA0000, 1'b0);
    send(32'hBBBB0000, 1'b1);
    chk("early_err",   {127'b0, bus.key_err},    128'd1);
    chk("early_wkey",  {58'b0, bus.working_key}, 128'd0);
    chk("early_ready", {127'b0, bus.key_ready},  128'd0);
    bus.key_clear = 1'b1;
    tick();
    bus.key_clear = 1'b0;
    chk("early_clr_err",   {127'b0, bus.key_err},   128'd0);
    chk("early_clr_ready", {127'b0, bus.key_ready}, 128'd1);

    // final chunk without key_last
    send(32'h1, 1'b0);
    send(32'h2, 1'b0);
    send(32'h3, 1'b0);
    chk("nolast_err",    {127'b0, bus.key_err},    128'd1);
    chk("nolast_loaded", {127'b0, bus.key_loaded}, 128'd0);
    bus.key_clear = 1'b1;
    tick();
    bus.key_clear = 1'b0;

    // clear and transfer on the same cycle: chunk dropped, counter restarts
    send(32'hDEADBEEF, 1'b0);
    bus.key_valid = 1'b1;
    bus.key_data  = 32'hCAFEF00D;
    bus.key_clear = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    bus.key_clear = 1'b0;
    chk("clrx_wkey",  {58'b0, bus.working_key}, 128'd0);
    chk("clrx_ready", {127'b0, bus.key_ready},  128'd1);
    key_a = {$urandom, $urandom, $urandom};
    load_key(key_a[31:0], key_a[63:32], {26'h3FFFFFF, key_a[69:64]});
    check_key("clrx_reload");
    bus.key_clear = 1'b1;
    tick();
    bus.key_clear = 1'b0;

    // reset in the middle of a load, then a clean reload
    send(32'h12345678, 1'b0);
    send(32'h9ABCDEF0, 1'b0);
    ap_rst = 1'b1;
    tick();
    ap_rst = 1'b0;
    check_reset_outputs("midrst");
    load_key(32'h11111111, 32'h22222222, 32'hFFFFFFC5);
    check_key("midrst_reload");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // hard stop if the sequence above ever stalls
  initial begin
    #200000;
    $display("FAIL timeout: observed stalled sequence, required completion");
    $fatal(1);
  end

endmodule
